// File: rtl/spi_manager_engine.sv
// ---------------------------------------------------------------------------
// spi_manager_engine
//   Single-byte SPI manager. A byte offered on tx_data/tx_valid is accepted in
//   IDLE (tx_ready high). The transfer runs SETUP -> TRANSFER -> HOLD and then
//   returns to IDLE, where the received byte is presented with a one-cycle
//   rx_valid strobe. The SCLK half-period is clock_divider+1 system clocks.
//   cpol, cpha, clock_divider and tx_data are captured at acceptance, so later
//   changes on those inputs do not disturb a transfer that is already running.
//
// Ports
//   clock          system clock, everything runs on its rising edge
//   reset_n        synchronous active-low reset
//   cpol           SCLK idle level
//   cpha           0: sample on leading edge, 1: sample on trailing edge
//   clock_divider  SCLK half-period minus one, in system clocks
//   tx_data        byte to send (MSB first)
//   tx_valid       request to send tx_data
//   tx_ready       high only in IDLE; handshake = tx_valid & tx_ready
//   rx_data        last received byte, held until the next completion
//   rx_valid       one-cycle strobe when rx_data updates
//   busy           high while a transfer is in progress
//   sclk/mosi/miso SPI bus signals
//   cs             active-low chip select
// ---------------------------------------------------------------------------
module spi_manager_engine #(
    parameter int DIVIDER_WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     cpol,
    input  logic                     cpha,
    input  logic [DIVIDER_WIDTH-1:0] clock_divider,
    input  logic [7:0]               tx_data,
    input  logic                     tx_valid,
    output logic                     tx_ready,
    output logic [7:0]               rx_data,
    output logic                     rx_valid,
    output logic                     busy,
    output logic                     sclk,
    output logic                     mosi,
    input  logic                     miso,
    output logic                     cs
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_SETUP    = 2'd1;
    localparam logic [1:0] ST_TRANSFER = 2'd2;
    localparam logic [1:0] ST_HOLD     = 2'd3;

    localparam logic [DIVIDER_WIDTH-1:0] CNT_ONE = {{(DIVIDER_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]               state_r;
    logic                     cpol_r;
    logic                     cpha_r;
    logic [DIVIDER_WIDTH-1:0] div_r;
    logic [DIVIDER_WIDTH-1:0] cnt_r;
    logic [3:0]               edge_cnt_r;   // SCLK edges already produced (0..15)
    logic [7:0]               tx_sh_r;
    logic [7:0]               rx_sh_r;
    logic                     sclk_r;
    logic                     mosi_r;
    logic                     cs_r;
    logic                     busy_r;
    logic                     tx_ready_r;
    logic                     rx_valid_r;
    logic [7:0]               rx_data_r;

    logic                     half_done_s;
    logic                     lead_s;
    logic                     last_edge_s;
    logic                     edge_s;
    logic                     sample_s;
    logic                     shift_s;

    assign half_done_s = (cnt_r == div_r);
    // The edge about to happen is number edge_cnt_r+1; odd numbers are leading edges.
    assign lead_s      = ~edge_cnt_r[0];
    assign last_edge_s = (edge_cnt_r == 4'd15);

    // Decode which SCLK edge happens this cycle and whether it samples or shifts.
    always_comb begin
        edge_s   = 1'b0;
        sample_s = 1'b0;
        shift_s  = 1'b0;
        if (((state_r == ST_SETUP) || (state_r == ST_TRANSFER)) && half_done_s) begin
            edge_s   = 1'b1;
            sample_s = lead_s ^ cpha_r;
            if (cpha_r) begin
                // First leading edge presents bit 7, later leading edges the rest.
                shift_s = lead_s;
            end else begin
                // Bit 7 was presented at acceptance; the final trailing edge has nothing left.
                shift_s = ~lead_s & ~last_edge_s;
            end
        end else begin
            edge_s   = 1'b0;
            sample_s = 1'b0;
            shift_s  = 1'b0;
        end
    end

    // Transfer sequencer: state, half-period timing, shift registers and all outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cpol_r     <= 1'b0;
            cpha_r     <= 1'b0;
            div_r      <= '0;
            cnt_r      <= '0;
            edge_cnt_r <= 4'd0;
            tx_sh_r    <= 8'h00;
            rx_sh_r    <= 8'h00;
            sclk_r     <= 1'b0;
            mosi_r     <= 1'b0;
            cs_r       <= 1'b1;
            busy_r     <= 1'b0;
            tx_ready_r <= 1'b1;
            rx_valid_r <= 1'b0;
            rx_data_r  <= 8'h00;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    rx_valid_r <= 1'b0;
                    sclk_r     <= cpol;
                    if (tx_valid && tx_ready_r) begin
                        state_r    <= ST_SETUP;
                        cpol_r     <= cpol;
                        cpha_r     <= cpha;
                        div_r      <= clock_divider;
                        cnt_r      <= '0;
                        edge_cnt_r <= 4'd0;
                        rx_sh_r    <= 8'h00;
                        cs_r       <= 1'b0;
                        busy_r     <= 1'b1;
                        tx_ready_r <= 1'b0;
                        if (!cpha) begin
                            mosi_r  <= tx_data[7];
                            tx_sh_r <= {tx_data[6:0], 1'b0};
                        end else begin
                            tx_sh_r <= tx_data;
                        end
                    end else begin
                        cs_r       <= 1'b1;
                        busy_r     <= 1'b0;
                        tx_ready_r <= 1'b1;
                    end
                end
                ST_SETUP, ST_TRANSFER: begin
                    if (edge_s) begin
                        cnt_r      <= '0;
                        sclk_r     <= ~sclk_r;
                        edge_cnt_r <= edge_cnt_r + 4'd1;
                        if (sample_s) begin
                            rx_sh_r <= {rx_sh_r[6:0], miso};
                        end
                        if (shift_s) begin
                            mosi_r  <= tx_sh_r[7];
                            tx_sh_r <= {tx_sh_r[6:0], 1'b0};
                        end
                        if (last_edge_s) begin
                            state_r <= ST_HOLD;
                        end else begin
                            state_r <= ST_TRANSFER;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (half_done_s) begin
                        state_r    <= ST_IDLE;
                        cnt_r      <= '0;
                        cs_r       <= 1'b1;
                        busy_r     <= 1'b0;
                        tx_ready_r <= 1'b1;
                        rx_valid_r <= 1'b1;
                        rx_data_r  <= rx_sh_r;
                        sclk_r     <= cpol_r;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cs_r       <= 1'b1;
                    busy_r     <= 1'b0;
                    tx_ready_r <= 1'b1;
                    rx_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign tx_ready = tx_ready_r;
    assign rx_data  = rx_data_r;
    assign rx_valid = rx_valid_r;
    assign busy     = busy_r;
    assign sclk     = sclk_r;
    assign mosi     = mosi_r;
    assign cs       = cs_r;

endmodule

// File: tb/tb_spi_manager_engine.sv
// ---------------------------------------------------------------------------
// tb_spi_manager_engine
//   Directed bench for spi_manager_engine. miso is taken from a loopback of
//   mosi, a constant 1, or a behavioural echo subordinate that returns the
//   byte it received during the previous chip-select window.
// ---------------------------------------------------------------------------
module tb_spi_manager_engine;

    logic        clock;
    logic        reset_n;
    logic        cpol;
    logic        cpha;
    logic [15:0] clock_divider;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        busy;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        cs;

    int checks   = 0;
    int failures = 0;

    // miso source: 0 loopback, 1 tied high, 2 echo subordinate
    int          miso_sel = 0;
    logic        sub_miso = 1'b0;
    logic        sub_pha  = 1'b0;
    logic        sub_rise = 1'b1;   // 1: subordinate samples on rising sclk
    logic [7:0]  sub_in   = 8'h00;
    logic [7:0]  sub_out  = 8'h96;
    int          sub_idx  = 0;

    // transfer statistics gathered by run_xfer
    int          lat, cs_low, toggles, first_tog, bad_gap, mosi_hi, ready_busy, busy_low;
    logic [7:0]  rx_got;
    logic        got_valid;

    spi_manager_engine #(.DIVIDER_WIDTH(16)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .cpol          (cpol),
        .cpha          (cpha),
        .clock_divider (clock_divider),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .busy          (busy),
        .sclk          (sclk),
        .mosi          (mosi),
        .miso          (miso),
        .cs            (cs)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign miso = (miso_sel == 0) ? mosi : ((miso_sel == 1) ? 1'b1 : sub_miso);

    // Echo subordinate: load the echo byte and present the first bit when selected.
    always @(negedge cs) begin
        if (miso_sel == 2) begin
            if (!sub_pha) begin
                sub_miso = sub_out[7];
                sub_idx  = 6;
            end else begin
                sub_idx = 7;
            end
        end
    end

    // Echo subordinate: the byte just received becomes the next reply.
    always @(posedge cs) begin
        if (miso_sel == 2) sub_out = sub_in;
    end

    // Echo subordinate: sample on one sclk edge, update miso on the other.
    always @(sclk) begin
        if (miso_sel == 2 && cs == 1'b0) begin
            if (sclk == sub_rise) begin
                sub_in = {sub_in[6:0], mosi};
            end else if (sub_idx >= 0) begin
                sub_miso = sub_out[sub_idx];
                sub_idx  = sub_idx - 1;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Offer a byte from a negedge and return just after the handshake edge.
    task automatic start(input logic [7:0] d, input logic pol, input logic pha,
                         input logic [15:0] dv, input logic hold);
        int n;
        tx_data       = d;
        cpol          = pol;
        cpha          = pha;
        clock_divider = dv;
        tx_valid      = 1'b1;
        n = 0;
        while (!tx_ready && n < 1000) begin
            @(negedge clock);
            n++;
        end
        check_val("hs_ready", {31'd0, tx_ready}, 32'd1);
        @(posedge clock);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Observe one transfer, one sample per negedge, until rx_valid or a cycle budget.
    task automatic run_xfer(input int h, input logic pol, input int chg);
        logic prev;
        int   last_t;
        lat = 0; cs_low = 0; toggles = 0; first_tog = 0; bad_gap = 0;
        mosi_hi = 0; ready_busy = 0; busy_low = 0; prev = pol; last_t = 0;
        while (lat < 17 * h + 50) begin
            @(negedge clock);
            lat++;
            if (rx_valid) break;
            if (lat == chg) begin
                cpha          = ~cpha;
                clock_divider = 16'd0;
                tx_data       = 8'h7E;
            end
            if (!cs) cs_low++;
            if (!busy) busy_low++;
            if (tx_ready) ready_busy++;
            if (mosi) mosi_hi++;
            if (sclk !== prev) begin
                toggles++;
                if (toggles == 1) first_tog = lat;
                else if (lat - last_t != h) bad_gap++;
                last_t = lat;
                prev   = sclk;
            end
        end
        rx_got    = rx_data;
        got_valid = rx_valid;
    endtask

    task automatic check_done(input string tag, input int h, input logic [7:0] exp_rx, input logic pol);
        check_val({tag, "_lat"},    lat, 17 * h + 1);
        check_val({tag, "_valid"},  {31'd0, got_valid}, 32'd1);
        check_val({tag, "_rx"},     {24'd0, rx_got}, {24'd0, exp_rx});
        check_val({tag, "_cs_low"}, cs_low, 17 * h);
        check_val({tag, "_tog"},    toggles, 16);
        check_val({tag, "_first"},  first_tog, 1 + h);
        check_val({tag, "_gap"},    bad_gap, 0);
        check_val({tag, "_busy"},   busy_low, 0);
        check_val({tag, "_rdy"},    ready_busy, 0);
        check_val({tag, "_end"},    {28'd0, cs, busy, tx_ready, sclk}, {28'd0, 1'b1, 1'b0, 1'b1, pol});
    endtask

    initial begin
        int nvalid;
        reset_n = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        cpol = 1'b0; cpha = 1'b0; clock_divider = 16'd0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check_val("rst_outs", {27'd0, cs, sclk, mosi, busy, rx_valid}, {27'd0, 5'b10000});
        check_val("rst_rx",   {24'd0, rx_data}, 32'h00);
        check_val("rst_rdy",  {31'd0, tx_ready}, 32'd1);
        reset_n = 1'b1;
        @(negedge clock);
        check_val("rel_outs", {26'd0, cs, sclk, mosi, busy, rx_valid, tx_ready}, {26'd0, 6'b100001});

        // mode 0, divider 0, loopback
        miso_sel = 0;
        start(8'hA5, 1'b0, 1'b0, 16'd0, 1'b0);
        run_xfer(1, 1'b0, 0);
        check_done("lb_a5", 1, 8'hA5, 1'b0);
        @(negedge clock);
        check_val("lb_strobe", {31'd0, rx_valid}, 32'd0);
        check_val("lb_hold",   {24'd0, rx_data}, 32'hA5);

        // mode 0 echo subordinate (rising sample, falling update)
        miso_sel = 2; sub_pha = 1'b0; sub_rise = 1'b1;
        start(8'h3C, 1'b0, 1'b0, 16'd1, 1'b0);
        run_xfer(2, 1'b0, 0);
        check_done("m0_b1", 2, 8'h96, 1'b0);
        start(8'hC3, 1'b0, 1'b0, 16'd1, 1'b0);
        run_xfer(2, 1'b0, 0);
        check_done("m0_b2", 2, 8'h3C, 1'b0);

        // mode 1 echo subordinate (falling sample)
        sub_pha = 1'b1; sub_rise = 1'b0;
        @(negedge clock);
        start(8'h3C, 1'b0, 1'b1, 16'd2, 1'b0);
        run_xfer(3, 1'b0, 0);
        check_done("m1_b1", 3, 8'hC3, 1'b0);
        start(8'hC3, 1'b0, 1'b1, 16'd2, 1'b0);
        run_xfer(3, 1'b0, 0);
        check_done("m1_b2", 3, 8'h3C, 1'b0);

        // mode 2 echo subordinate; let sclk settle to the new idle level first
        sub_pha = 1'b0; sub_rise = 1'b0;
        cpol = 1'b1;
        repeat (2) @(negedge clock);
        check_val("m2_idle", {31'd0, sclk}, 32'd1);
        start(8'h3C, 1'b1, 1'b0, 16'd0, 1'b0);
        run_xfer(1, 1'b1, 0);
        check_done("m2_b1", 1, 8'hC3, 1'b1);
        start(8'hC3, 1'b1, 1'b0, 16'd0, 1'b0);
        run_xfer(1, 1'b1, 0);
        check_done("m2_b2", 1, 8'h3C, 1'b1);
        repeat (3) @(negedge clock);
        check_val("m2_idle2", {31'd0, sclk}, 32'd1);

        // divider 3, miso tied high, all-zero byte
        miso_sel = 1;
        cpol = 1'b0;
        repeat (2) @(negedge clock);
        start(8'h00, 1'b0, 1'b0, 16'd3, 1'b0);
        run_xfer(4, 1'b0, 0);
        check_done("d3", 4, 8'hFF, 1'b0);
        check_val("d3_mosi", mosi_hi, 0);

        // settings change mid-transfer with tx_valid held; second byte back-to-back
        miso_sel = 0;
        start(8'h81, 1'b0, 1'b0, 16'd1, 1'b1);
        run_xfer(2, 1'b0, 10);
        check_done("chg_b1", 2, 8'h81, 1'b0);
        @(posedge clock);
        #1;
        tx_valid = 1'b0;
        run_xfer(1, 1'b0, 0);
        check_done("chg_b2", 1, 8'h7E, 1'b0);

        // reset after edge 7, then a clean transfer
        @(negedge clock);
        start(8'hF0, 1'b0, 1'b0, 16'd1, 1'b0);
        nvalid = 0;
        repeat (15) begin
            @(negedge clock);
            if (rx_valid) nvalid++;
        end
        check_val("ab_sclk7", {31'd0, sclk}, 32'd1);
        reset_n = 1'b0;
        @(negedge clock);
        check_val("ab_outs", {26'd0, cs, sclk, busy, rx_valid, tx_ready, mosi}, {26'd0, 6'b100010});
        check_val("ab_rx", {24'd0, rx_data}, 32'h00);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) begin
            @(negedge clock);
            if (rx_valid) nvalid++;
        end
        check_val("ab_novalid", nvalid, 0);
        start(8'h5A, 1'b0, 1'b0, 16'd0, 1'b0);
        run_xfer(1, 1'b0, 0);
        check_done("ab_5a", 1, 8'h5A, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
